alu_cmd_sequencer: RTL and testbench

- Frame-level controller that sequences the shared ALU/compare datapath from a byte stream (UART RX side) and returns results to the TX side.
- Collects a 4-byte command frame (header, operand A, operand B, function), drives operands and a one-cycle enable into the datapath, captures the registered result, and emits it over a valid/ready handshake.
- Sits between the RX data-sync stage and the ALU/CMP units in the system-control domain.

---
 rtl/alu_cmd_sequencer.sv | 180 ++++++++++++++++++
 tb/tb_alu_cmd_sequencer.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_cmd_sequencer.sv
// Frame-level sequencer: collects header/A/B/function bytes from RX, fires the shared
// ALU/CMP datapath for one cycle, captures its registered result and hands it to TX.
module alu_cmd_sequencer #(
    parameter int         DATA_WIDTH = 8,
    parameter int         FUN_WIDTH  = 4,
    parameter logic [7:0] HDR_CMD    = 8'hCC,
    parameter int         TIMEOUT    = 255
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [7:0]            RX_DATA,
    input  logic                  RX_VALID,
    input  logic [DATA_WIDTH-1:0] ALU_OUT,
    input  logic                  TX_READY,
    output logic [DATA_WIDTH-1:0] ALU_A,
    output logic [DATA_WIDTH-1:0] ALU_B,
    output logic [FUN_WIDTH-1:0]  ALU_FUN,
    output logic                  ALU_EN,
    output logic [DATA_WIDTH-1:0] TX_DATA,
    output logic                  TX_VALID,
    output logic                  BUSY,
    output logic                  ERR,
    output logic [7:0]            CMD_CNT
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_GET_A   = 3'd1,
        S_GET_B   = 3'd2,
        S_GET_FUN = 3'd3,
        S_EXEC    = 3'd4,
        S_CAPTURE = 3'd5,
        S_SEND    = 3'd6
    } state_t;

    localparam logic [7:0] TIMEOUT_M1 = 8'(TIMEOUT - 1);

    // Function byte is legal only when every bit above the function field is zero.
    function automatic logic fun_byte_ok(input logic [7:0] b);
        return (b >> FUN_WIDTH) == 8'h00;
    endfunction

    state_t                  state_q, state_d;
    logic [DATA_WIDTH-1:0]   alu_a_q, alu_a_d;
    logic [DATA_WIDTH-1:0]   alu_b_q, alu_b_d;
    logic [FUN_WIDTH-1:0]    alu_fun_q, alu_fun_d;
    logic                    alu_en_q, alu_en_d;
    logic [DATA_WIDTH-1:0]   tx_data_q, tx_data_d;
    logic                    tx_valid_q, tx_valid_d;
    logic                    err_q, err_d;
    logic [7:0]              cmd_cnt_q, cmd_cnt_d;
    logic [7:0]              gap_q, gap_d;

    // Next-state and next-output logic; ALU_EN is raised on the edge that enters EXEC.
    always_comb begin
        state_d    = state_q;
        alu_a_d    = alu_a_q;
        alu_b_d    = alu_b_q;
        alu_fun_d  = alu_fun_q;
        alu_en_d   = 1'b0;
        tx_data_d  = tx_data_q;
        tx_valid_d = tx_valid_q;
        err_d      = 1'b0;
        cmd_cnt_d  = cmd_cnt_q;
        gap_d      = 8'd0;
        case (state_q)
            S_IDLE: begin
                if (RX_VALID) begin
                    if (RX_DATA == HDR_CMD) begin
                        state_d = S_GET_A;
                    end else begin
                        err_d = 1'b1;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_GET_A: begin
                if (RX_VALID) begin
                    alu_a_d = DATA_WIDTH'(RX_DATA);
                    state_d = S_GET_B;
                end else if (gap_q == TIMEOUT_M1) begin
                    state_d = S_IDLE;
                    err_d   = 1'b1;
                end else begin
                    gap_d = gap_q + 8'd1;
                end
            end
            S_GET_B: begin
                if (RX_VALID) begin
                    alu_b_d = DATA_WIDTH'(RX_DATA);
                    state_d = S_GET_FUN;
                end else if (gap_q == TIMEOUT_M1) begin
                    state_d = S_IDLE;
                    err_d   = 1'b1;
                end else begin
                    gap_d = gap_q + 8'd1;
                end
            end
            S_GET_FUN: begin
                if (RX_VALID) begin
                    if (fun_byte_ok(RX_DATA)) begin
                        alu_fun_d = FUN_WIDTH'(RX_DATA);
                        alu_en_d  = 1'b1;
                        state_d   = S_EXEC;
                    end else begin
                        state_d = S_IDLE;
                        err_d   = 1'b1;
                    end
                end else if (gap_q == TIMEOUT_M1) begin
                    state_d = S_IDLE;
                    err_d   = 1'b1;
                end else begin
                    gap_d = gap_q + 8'd1;
                end
            end
            S_EXEC: begin
                err_d   = RX_VALID;
                state_d = S_CAPTURE;
            end
            S_CAPTURE: begin
                err_d      = RX_VALID;
                tx_data_d  = ALU_OUT;
                tx_valid_d = 1'b1;
                state_d    = S_SEND;
            end
            S_SEND: begin
                err_d = RX_VALID;
                if (tx_valid_q && TX_READY) begin
                    tx_valid_d = 1'b0;
                    cmd_cnt_d  = cmd_cnt_q + 8'd1;
                    state_d    = S_IDLE;
                end else begin
                    state_d = S_SEND;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers; reset clears everything and discards any partial frame.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q    <= S_IDLE;
            alu_a_q    <= '0;
            alu_b_q    <= '0;
            alu_fun_q  <= '0;
            alu_en_q   <= 1'b0;
            tx_data_q  <= '0;
            tx_valid_q <= 1'b0;
            err_q      <= 1'b0;
            cmd_cnt_q  <= 8'd0;
            gap_q      <= 8'd0;
        end else begin
            state_q    <= state_d;
            alu_a_q    <= alu_a_d;
            alu_b_q    <= alu_b_d;
            alu_fun_q  <= alu_fun_d;
            alu_en_q   <= alu_en_d;
            tx_data_q  <= tx_data_d;
            tx_valid_q <= tx_valid_d;
            err_q      <= err_d;
            cmd_cnt_q  <= cmd_cnt_d;
            gap_q      <= gap_d;
        end
    end

    assign ALU_A    = alu_a_q;
    assign ALU_B    = alu_b_q;
    assign ALU_FUN  = alu_fun_q;
    assign ALU_EN   = alu_en_q;
    assign TX_DATA  = tx_data_q;
    assign TX_VALID = tx_valid_q;
    assign ERR      = err_q;
    assign CMD_CNT  = cmd_cnt_q;
    assign BUSY     = (state_q != S_IDLE);

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Bench for alu_cmd_sequencer: frame-level reference model, per-cycle compare process,
// directed scenarios with literal expectations and a randomized 256-frame run.
module tb_alu_cmd_sequencer;

    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic [7:0] RX_DATA = 8'h00;
    logic       RX_VALID = 1'b0;
    logic [7:0] ALU_OUT = 8'h00;
    logic       TX_READY = 1'b0;
    logic [7:0] ALU_A, ALU_B, TX_DATA, CMD_CNT;
    logic [3:0] ALU_FUN;
    logic       ALU_EN, TX_VALID, BUSY, ERR;

    int n_checks = 0;
    int n_fail   = 0;

    alu_cmd_sequencer dut (
        .CLK(CLK), .RST(RST), .RX_DATA(RX_DATA), .RX_VALID(RX_VALID),
        .ALU_OUT(ALU_OUT), .TX_READY(TX_READY), .ALU_A(ALU_A), .ALU_B(ALU_B),
        .ALU_FUN(ALU_FUN), .ALU_EN(ALU_EN), .TX_DATA(TX_DATA), .TX_VALID(TX_VALID),
        .BUSY(BUSY), .ERR(ERR), .CMD_CNT(CMD_CNT)
    );

    always #5 CLK = ~CLK;

    // Datapath stand-in: compare codes 1/2/3 return 1/2/3 when true, 0 otherwise.
    function automatic logic [7:0] alu_ref(input logic [7:0] a, input logic [7:0] b,
                                           input logic [3:0] f);
        case (f)
            4'd0:    return a + b;
            4'd1:    return (a == b) ? 8'd1 : 8'd0;
            4'd2:    return (a > b) ? 8'd2 : 8'd0;
            4'd3:    return (a < b) ? 8'd3 : 8'd0;
            4'd4:    return a - b;
            4'd5:    return a & b;
            4'd6:    return a | b;
            4'd7:    return a ^ b;
            4'd8:    return 8'(a * b);
            default: return ~(a ^ b) + {4'h0, f};
        endcase
    endfunction

    // Registered datapath; outside an enable it outputs noise so mistimed captures show up.
    always @(posedge CLK) begin
        ALU_OUT <= ALU_EN ? alu_ref(ALU_A, ALU_B, ALU_FUN) : 8'($urandom);
    end

    // Reference model: expected outputs after each edge.
    logic [7:0] m_a = 8'h00, m_b = 8'h00, m_txd = 8'h00, m_cnt = 8'h00;
    logic [3:0] m_fun = 4'h0;
    logic       m_en = 1'b0, m_txv = 1'b0, m_err = 1'b0;
    logic [7:0] frame_q[$];
    int         m_gap = 0;
    int         m_age = 0;
    bit         m_sending = 1'b0;

    function automatic logic m_busy();
        return (frame_q.size() != 0) || (m_age != 0) || m_sending;
    endfunction

    task automatic model_reset();
        m_a = 8'h00; m_b = 8'h00; m_txd = 8'h00; m_cnt = 8'h00; m_fun = 4'h0;
        m_en = 1'b0; m_txv = 1'b0; m_err = 1'b0;
        frame_q.delete(); m_gap = 0; m_age = 0; m_sending = 1'b0;
    endtask

    task automatic model_step(input logic v, input logic [7:0] d, input logic r);
        m_err = 1'b0;
        m_en  = 1'b0;
        if (m_sending) begin
            m_err = v;
            if (r) begin
                m_txv = 1'b0;
                m_cnt = m_cnt + 8'd1;
                m_sending = 1'b0;
            end
        end else if (m_age == 2) begin
            m_err = v;
            m_txd = alu_ref(m_a, m_b, m_fun);
            m_txv = 1'b1;
            m_sending = 1'b1;
            m_age = 0;
        end else if (m_age == 1) begin
            m_err = v;
            m_age = 2;
        end else if (frame_q.size() == 0) begin
            if (v) begin
                if (d == 8'hCC) begin
                    frame_q.push_back(d);
                    m_gap = 0;
                end else begin
                    m_err = 1'b1;
                end
            end
        end else if (v) begin
            m_gap = 0;
            if (frame_q.size() == 1) m_a = d;
            else if (frame_q.size() == 2) m_b = d;
            else if (d[7:4] == 4'h0) begin
                m_fun = d[3:0];
                m_en  = 1'b1;
                m_age = 1;
            end else m_err = 1'b1;
            if (frame_q.size() == 3) frame_q.delete();
            else frame_q.push_back(d);
        end else begin
            m_gap++;
            if (m_gap == 255) begin
                frame_q.delete();
                m_err = 1'b1;
            end
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle compare of every output against the model.
    always @(negedge CLK) begin
        chk("alu_a",    32'(ALU_A),    32'(m_a));
        chk("alu_b",    32'(ALU_B),    32'(m_b));
        chk("alu_fun",  32'(ALU_FUN),  32'(m_fun));
        chk("alu_en",   32'(ALU_EN),   32'(m_en));
        chk("tx_data",  32'(TX_DATA),  32'(m_txd));
        chk("tx_valid", 32'(TX_VALID), 32'(m_txv));
        chk("busy",     32'(BUSY),     32'(m_busy()));
        chk("err",      32'(ERR),      32'(m_err));
        chk("cmd_cnt",  32'(CMD_CNT),  32'(m_cnt));
    end

    task automatic step(input logic v, input logic [7:0] d, input logic r);
        RX_VALID = v;
        RX_DATA  = d;
        TX_READY = r;
        @(posedge CLK);
        model_step(v, d, r);
        @(negedge CLK);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 8'($urandom), 1'b0);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_a"},   32'(ALU_A),    32'd0);
        chk({tag, "_b"},   32'(ALU_B),    32'd0);
        chk({tag, "_fun"}, 32'(ALU_FUN),  32'd0);
        chk({tag, "_en"},  32'(ALU_EN),   32'd0);
        chk({tag, "_txd"}, 32'(TX_DATA),  32'd0);
        chk({tag, "_txv"}, 32'(TX_VALID), 32'd0);
        chk({tag, "_bsy"}, 32'(BUSY),     32'd0);
        chk({tag, "_err"}, 32'(ERR),      32'd0);
        chk({tag, "_cnt"}, 32'(CMD_CNT),  32'd0);
    endtask

    initial begin
        repeat (3) @(negedge CLK);
        chk_all_zero("reset");
        RST = 1'b1;
        idle(2);

        // Frame 1: CC,05,03,01 -> A==B false -> 00; latency pinned literally.
        step(1'b1, 8'hCC, 1'b0); step(1'b1, 8'h05, 1'b0);
        step(1'b1, 8'h03, 1'b0); step(1'b1, 8'h01, 1'b0);
        chk("f1_en",  32'(ALU_EN), 32'd1);
        chk("f1_a",   32'(ALU_A), 32'h05);
        chk("f1_b",   32'(ALU_B), 32'h03);
        chk("f1_fun", 32'(ALU_FUN), 32'h1);
        step(1'b0, 8'h00, 1'b1);
        chk("f1_en_off", 32'(ALU_EN), 32'd0);
        chk("f1_txv_early", 32'(TX_VALID), 32'd0);
        step(1'b0, 8'h00, 1'b1);
        chk("f1_txv", 32'(TX_VALID), 32'd1);
        chk("f1_txd", 32'(TX_DATA), 32'h00);
        step(1'b0, 8'h00, 1'b1);
        chk("f1_txv_done", 32'(TX_VALID), 32'd0);
        chk("f1_cnt", 32'(CMD_CNT), 32'd1);
        chk("f1_busy", 32'(BUSY), 32'd0);

        // Frame 2: CC,09,04,02 with TX_READY held low; a byte injected mid-SEND.
        step(1'b1, 8'hCC, 1'b0); step(1'b1, 8'h09, 1'b0);
        step(1'b1, 8'h04, 1'b0); step(1'b1, 8'h02, 1'b0);
        idle(2);
        for (int i = 0; i < 10; i++) begin
            if (i == 5) begin
                step(1'b1, 8'hCC, 1'b0);
                chk("f2_inject_err", 32'(ERR), 32'd1);
            end else begin
                step(1'b0, 8'h00, 1'b0);
            end
            chk("f2_hold_txv", 32'(TX_VALID), 32'd1);
            chk("f2_hold_txd", 32'(TX_DATA), 32'h02);
        end
        step(1'b0, 8'h00, 1'b1);
        chk("f2_cnt", 32'(CMD_CNT), 32'd2);
        chk("f2_busy", 32'(BUSY), 32'd0);
        step(1'b0, 8'h00, 1'b1);
        chk("f2_once", 32'(CMD_CNT), 32'd2);

        // Bad header then bad function byte.
        step(1'b1, 8'h55, 1'b0);
        chk("hdr_err", 32'(ERR), 32'd1);
        chk("hdr_busy", 32'(BUSY), 32'd0);
        step(1'b1, 8'hCC, 1'b0);
        chk("hdr_err_clr", 32'(ERR), 32'd0);
        step(1'b1, 8'h01, 1'b0); step(1'b1, 8'h02, 1'b0); step(1'b1, 8'hF3, 1'b0);
        chk("fun_err", 32'(ERR), 32'd1);
        chk("fun_busy", 32'(BUSY), 32'd0);
        chk("fun_keep", 32'(ALU_FUN), 32'h2);
        idle(3);
        chk("fun_cnt", 32'(CMD_CNT), 32'd2);

        // Timeout: CC,07 then 255 idle cycles.
        step(1'b1, 8'hCC, 1'b0); step(1'b1, 8'h07, 1'b0);
        idle(254);
        chk("to_busy_before", 32'(BUSY), 32'd1);
        chk("to_err_before", 32'(ERR), 32'd0);
        idle(1);
        chk("to_err", 32'(ERR), 32'd1);
        chk("to_busy", 32'(BUSY), 32'd0);
        step(1'b1, 8'hCC, 1'b0); step(1'b1, 8'h10, 1'b0);
        step(1'b1, 8'h20, 1'b0); step(1'b1, 8'h00, 1'b0);
        idle(2);
        chk("to_next_txd", 32'(TX_DATA), 32'h30);
        step(1'b0, 8'h00, 1'b1);
        chk("to_next_cnt", 32'(CMD_CNT), 32'd3);

        // Asynchronous reset while in GET_B.
        step(1'b1, 8'hCC, 1'b0); step(1'b1, 8'h11, 1'b0);
        #2 RST = 1'b0;
        model_reset();
        #1 chk_all_zero("midrst");
        @(negedge CLK);
        @(negedge CLK);
        RST = 1'b1;
        idle(1);

        // 256 random valid frames with noise, gaps and random TX_READY.
        for (int f = 0; f < 256; f++) begin
            logic [7:0] fb [4];
            if ($urandom_range(0, 7) == 0) step(1'b1, 8'h5A, 1'b0);
            fb[0] = 8'hCC;
            fb[1] = 8'($urandom);
            fb[2] = 8'($urandom);
            fb[3] = {4'h0, 4'($urandom)};
            for (int k = 0; k < 4; k++) begin
                idle($urandom_range(0, 3));
                step(1'b1, fb[k], 1'($urandom));
            end
            for (int c = 0; c < 100 && BUSY; c++) begin
                step(($urandom_range(0, 3) == 0), 8'($urandom), 1'($urandom));
            end
            chk("rnd_frame_done", 32'(BUSY), 32'd0);
            if (f == 254) chk("rnd_cnt_255", 32'(CMD_CNT), 32'd255);
        end
        chk("rnd_cnt_wrap", 32'(CMD_CNT), 32'd0);
        idle(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
